// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, one full-subtractor cell, start/done handshake.
// Optional signed overflow flag on port ovf when SUB_SIGNED_OVF_EN is defined.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] sh_a_r;
    logic [WIDTH-1:0] sh_b_r;
    logic             br_r;
    logic [CW-1:0]    cnt_r;
    logic             d_s;
    logic             br_nxt_s;
    logic             last_bit_s;

`ifdef SUB_SIGNED_OVF_EN
    logic             sign_a_r;
    logic             sign_b_r;
`endif

    // Single full-subtractor cell acting on the current LSBs and the running borrow.
    always_comb begin
        d_s        = sh_a_r[0] ^ sh_b_r[0] ^ br_r;
        br_nxt_s   = (~sh_a_r[0] & sh_b_r[0]) | (~(sh_a_r[0] ^ sh_b_r[0]) & br_r);
        last_bit_s = (cnt_r == CW'(WIDTH - 1));
    end

    // Control FSM with registered handshake outputs and the serial datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            sh_a_r     <= {WIDTH{1'b0}};
            sh_b_r     <= {WIDTH{1'b0}};
            br_r       <= 1'b0;
            cnt_r      <= {CW{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= {WIDTH{1'b0}};
            borrow_out <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            sign_a_r   <= 1'b0;
            sign_b_r   <= 1'b0;
            ovf        <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a_r   <= a;
                        sh_b_r   <= b;
                        br_r     <= 1'b0;
                        cnt_r    <= {CW{1'b0}};
                        diff     <= {WIDTH{1'b0}};
                        busy     <= 1'b1;
`ifdef SUB_SIGNED_OVF_EN
                        sign_a_r <= a[WIDTH-1];
                        sign_b_r <= b[WIDTH-1];
`endif
                        state_r  <= SHIFT;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                SHIFT: begin
                    // Result bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
                    diff   <= {d_s, diff[WIDTH-1:1]};
                    br_r   <= br_nxt_s;
                    sh_a_r <= {1'b0, sh_a_r[WIDTH-1:1]};
                    sh_b_r <= {1'b0, sh_b_r[WIDTH-1:1]};
                    if (last_bit_s) begin
                        state_r <= DONE;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    borrow_out <= br_r;
`ifdef SUB_SIGNED_OVF_EN
                    ovf        <= (sign_a_r != sign_b_r) && (diff[WIDTH-1] != sign_a_r);
`endif
                    state_r    <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vector table, handshake corner sequences
// and randomized operations against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;
    localparam int LAT = W + 1;
    localparam int TMO = 40;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SUB_SIGNED_OVF_EN
    logic         ovf;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .borrow_out(borrow_out)
`ifdef SUB_SIGNED_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic.
    function automatic logic [W-1:0] m_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        int r;
        r = (int'(x) - int'(y) + 256) % 256;
        return r[W-1:0];
    endfunction

    function automatic logic m_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
        return (int'(x) < int'(y)) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic m_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
        int sx, sy, r;
        sx = (x >= 8'd128) ? int'(x) - 256 : int'(x);
        sy = (y >= 8'd128) ? int'(y) - 256 : int'(y);
        r  = sx - sy;
        return ((r > 127) || (r < -128)) ? 1'b1 : 1'b0;
    endfunction

    // One operation from an idle negedge; optional ignored start pulse at cycle inj.
    task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic [W-1:0] ediff, input logic eborrow, input logic eovf,
                          input int inj);
        int lat;
        lat = 0;
        a = xa; b = xb; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        @(negedge clk);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        for (int k = 1; k <= TMO; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (k == inj) begin
                a = ~xa; b = xa; start = 1'b1;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(LAT));
        chk({tag, "_diff"}, 32'(diff), 32'(ediff));
        chk({tag, "_borrow"}, 32'(borrow_out), 32'(eborrow));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
`ifdef SUB_SIGNED_OVF_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(eovf));
`else
        if (eovf === 1'bx) $display("unexpected ovf request");
`endif
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_diff_hold"}, 32'(diff), 32'(ediff));
    endtask

    vec_t vecs[$];

    initial begin
        int          cyc;
        int          nd;
        int          t_done[3];
        logic [W-1:0] ha[3];
        logic [W-1:0] hb[3];
        logic        seen;

        vecs.push_back('{8'd100, 8'd37,  8'd63,  1'b0, 1'b0});
        vecs.push_back('{8'd5,   8'd7,   8'hFE,  1'b1, 1'b0});
        vecs.push_back('{8'd0,   8'd255, 8'h01,  1'b1, 1'b0});
        vecs.push_back('{8'hA5,  8'hA5,  8'h00,  1'b0, 1'b0});
        vecs.push_back('{8'h80,  8'h01,  8'h7F,  1'b0, 1'b1});
        vecs.push_back('{8'hFF,  8'h00,  8'hFF,  1'b0, 1'b0});
        vecs.push_back('{8'h00,  8'h01,  8'hFF,  1'b1, 1'b0});
        vecs.push_back('{8'h7F,  8'hFF,  8'h80,  1'b1, 1'b1});

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow,
                   vecs[i].ovf, 0);

        // Start pulse mid-SHIFT must be ignored.
        run_op("midstart", 8'd100, 8'd37, 8'd63, 1'b0, 1'b0, 3);
        // Start pulse during the DONE state must also be ignored.
        run_op("donestart", 8'd20, 8'd50, 8'hE2, 1'b1, 1'b0, 8);

        // Reset during SHIFT aborts immediately with no done pulse afterwards.
        a = 8'd9; b = 8'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_borrow", 32'(borrow_out), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 2 * LAT; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        run_op("post_abort", 8'd9, 8'd3, 8'd6, 1'b0, 1'b0, 0);

        // Start held high: back-to-back operations spaced WIDTH+2 cycles.
        ha[0] = 8'd200; hb[0] = 8'd13;
        ha[1] = 8'd13;  hb[1] = 8'd200;
        ha[2] = 8'h55;  hb[2] = 8'hAA;
        a = ha[0]; b = hb[0]; start = 1'b1;
        cyc = 0; nd = 0;
        while (nd < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                t_done[nd] = cyc;
                chk($sformatf("hold%0d_diff", nd), 32'(diff), 32'(m_diff(ha[nd], hb[nd])));
                chk($sformatf("hold%0d_borrow", nd), 32'(borrow_out),
                    32'(m_borrow(ha[nd], hb[nd])));
                nd++;
                if (nd < 3) begin
                    a = ha[nd]; b = hb[nd];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("hold_count", 32'(nd), 32'd3);
        if (nd == 3) begin
            chk("hold_gap1", 32'(t_done[1] - t_done[0]), 32'(W + 2));
            chk("hold_gap2", 32'(t_done[2] - t_done[1]), 32'(W + 2));
        end
        repeat (3) @(negedge clk);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = (i % 8 == 0) ? ra : W'($urandom);
            run_op($sformatf("rnd%0d", i), ra, rb, m_diff(ra, rb), m_borrow(ra, rb),
                   m_ovf(ra, rb), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
